// File: rtl/lsu_pkg.sv
// Shared constants and types for the memory/writeback load-store unit.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_CSR  = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the byte/halfword lane and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata_i[8*offset_i +: 8];
    half_c = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_c[7]}}, byte_c};
      F3_H:    data_o = {{16{half_c[15]}}, half_c};
      F3_BU:   data_o = {24'h000000, byte_c};
      F3_HU:   data_o = {16'h0000, half_c};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mw_load_store_unit.sv
// Memory/writeback stage: data-memory handshake, store/load alignment, writeback mux.
// Optional feature: define MISALIGN_TRAP_EN to suppress and flag misaligned accesses.
module mw_load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [6:0]    opcode_mw,
  input  logic [2:0]    funct3_mw,
  input  logic [1:0]    wb_sel_mw,
  input  logic          reg_wr_mw,
  input  logic [DW-1:0] alu_res_mw,
  input  logic [DW-1:0] store_data_mw,
  input  logic [AW-1:0] pc_mw,
  input  logic [DW-1:0] csr_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          stall_mw,
  output logic          wb_en,
  output logic [DW-1:0] wb_data,
  output logic          misaligned
);

  lsu_state_e state_q, state_d;

  logic          is_load_c, is_store_c, mem_op_c, mis_c, issue_c;
  logic          req_c, stall_c;
  logic [1:0]    off_c;
  logic [DW-1:0] load_data_c;

  assign is_load_c  = (opcode_mw == OPC_LOAD);
  assign is_store_c = (opcode_mw == OPC_STORE);
  assign mem_op_c   = is_load_c | is_store_c;
  assign off_c      = alu_res_mw[1:0];
  assign issue_c    = mem_op_c & ~mis_c;

`ifdef MISALIGN_TRAP_EN
  // Byte accesses never trap; halfwords need a[0]=0; everything else is a word access.
  always_comb begin
    mis_c = 1'b0;
    if (mem_op_c) begin
      case (funct3_mw)
        F3_B, F3_BU: mis_c = 1'b0;
        F3_H:        mis_c = off_c[0];
        F3_HU:       mis_c = is_load_c ? off_c[0] : (|off_c);
        default:     mis_c = |off_c;
      endcase
    end
  end
`else
  assign mis_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Handshake: request held through REQ until grant; loads then wait for rvalid.
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_c) begin
          req_c = 1'b1;
          if (dmem_gnt) state_d = is_store_c ? IDLE : WAIT;
          else          state_d = REQ;
        end
      end
      REQ: begin
        if (issue_c) begin
          req_c = 1'b1;
          if (dmem_gnt) state_d = is_store_c ? IDLE : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dmem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall_c = issue_c
            & ~(is_store_c & dmem_gnt & (state_q != WAIT))
            & ~((state_q == WAIT) & dmem_rvalid);
    if (rst) begin
      req_c   = 1'b0;
      stall_c = 1'b0;
    end
  end

  assign dmem_req   = req_c;
  assign stall_mw   = stall_c;
  assign misaligned = mis_c & ~rst;
  assign wb_en      = reg_wr_mw & ~stall_c & ~mis_c & ~rst;
  assign dmem_we    = is_store_c;
  assign dmem_addr  = {alu_res_mw[AW-1:2], 2'b00};

  // Store lane enables and replicated write data; loads read the full word.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = store_data_mw;
    if (is_store_c) begin
      case (funct3_mw)
        F3_B: begin
          dmem_be    = 4'b0001 << off_c;
          dmem_wdata = {4{store_data_mw[7:0]}};
        end
        F3_H: begin
          dmem_be    = 4'b0011 << {off_c[1], 1'b0};
          dmem_wdata = {2{store_data_mw[15:0]}};
        end
        default: ;
      endcase
    end
  end

  lsu_load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .offset_i (off_c),
    .funct3_i (funct3_mw),
    .data_o   (load_data_c)
  );

  always_comb begin
    case (wb_sel_e'(wb_sel_mw))
      WB_ALU:  wb_data = alu_res_mw;
      WB_LOAD: wb_data = load_data_c;
      WB_PC4:  wb_data = DW'(pc_mw + AW'(4));
      WB_CSR:  wb_data = csr_rdata;
      default: wb_data = alu_res_mw;
    endcase
  end

endmodule

// File: tb/tb_mw_load_store_unit.sv
// Directed self-checking bench for mw_load_store_unit.
module tb_mw_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode_mw;
  logic [2:0]  funct3_mw;
  logic [1:0]  wb_sel_mw;
  logic        reg_wr_mw;
  logic [31:0] alu_res_mw, store_data_mw, pc_mw, csr_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_mw, wb_en;
  logic [31:0] wb_data;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] JAL   = 7'b1101111;

  always #5 clk = ~clk;

  mw_load_store_unit #(.DW(32), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .opcode_mw(opcode_mw), .funct3_mw(funct3_mw), .wb_sel_mw(wb_sel_mw),
    .reg_wr_mw(reg_wr_mw), .alu_res_mw(alu_res_mw), .store_data_mw(store_data_mw),
    .pc_mw(pc_mw), .csr_rdata(csr_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .stall_mw(stall_mw), .wb_en(wb_en), .wb_data(wb_data),
    .misaligned(misaligned)
  );

  task automatic set_idle();
    opcode_mw = OPIMM; funct3_mw = 3'b000; wb_sel_mw = 2'b00; reg_wr_mw = 1'b0;
    alu_res_mw = 32'h0; store_data_mw = 32'h0; pc_mw = 32'h0; csr_rdata = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    opcode_mw = LOAD; funct3_mw = 3'b010; wb_sel_mw = 2'b01; reg_wr_mw = 1'b1;
    alu_res_mw = 32'h100; dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({dmem_req, stall_mw, wb_en, misaligned} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got req/stall/wb_en/mis=%b exp 0000",
               {dmem_req, stall_mw, wb_en, misaligned});
    end
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    #1;
    checks++;
    if ({dmem_req, stall_mw} !== 2'b00) begin
      errors++; $display("FAIL reset_idle got req/stall=%b exp 00", {dmem_req, stall_mw});
    end
  endtask

  task automatic test_lw();
    @(negedge clk);
    opcode_mw = LOAD; funct3_mw = 3'b010; wb_sel_mw = 2'b01; reg_wr_mw = 1'b1;
    alu_res_mw = 32'h100; dmem_gnt = 1'b1;
    #1;
    checks++;
    if ({dmem_req, dmem_we, stall_mw, wb_en} !== 4'b1010 || dmem_addr !== 32'h100 ||
        dmem_be !== 4'b1111) begin
      errors++;
      $display("FAIL lw_req got req/we/stall/wb_en=%b addr=%h be=%b exp 1010 addr=00000100 be=1111",
               {dmem_req, dmem_we, stall_mw, wb_en}, dmem_addr, dmem_be);
    end
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({dmem_req, stall_mw, wb_en} !== 3'b001 || wb_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_data got req/stall/wb_en=%b data=%h exp 001 data=deadbeef",
               {dmem_req, stall_mw, wb_en}, wb_data);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_load_lanes();
    logic [2:0]  f3  [3] = '{3'b000, 3'b100, 3'b001};
    logic [31:0] adr [3] = '{32'h103, 32'h103, 32'h102};
    logic [31:0] rd  [3] = '{32'h80123456, 32'h80123456, 32'h8001ABCD};
    logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opcode_mw = LOAD; funct3_mw = f3[i]; wb_sel_mw = 2'b01; reg_wr_mw = 1'b1;
      alu_res_mw = adr[i]; dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
      #1;
      checks++;
      if (stall_mw !== 1'b1 || dmem_addr !== 32'h100) begin
        errors++; $display("FAIL lane%0d_req got stall=%b addr=%h exp 1 00000100", i, stall_mw, dmem_addr);
      end
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd[i];
      #1;
      checks++;
      if (wb_en !== 1'b1 || wb_data !== exp[i]) begin
        errors++; $display("FAIL lane%0d_data got wb_en=%b data=%h exp 1 %h", i, wb_en, wb_data, exp[i]);
      end
      @(negedge clk);
      set_idle();
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    opcode_mw = STORE; funct3_mw = 3'b000; alu_res_mw = 32'h102; store_data_mw = 32'h000000AB;
    for (int i = 0; i < 4; i++) begin
      dmem_gnt = (i == 3);
      #1;
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b0100 ||
          dmem_wdata !== 32'hABABABAB || dmem_addr !== 32'h100 || stall_mw !== (i < 3)) begin
        errors++;
        $display("FAIL sb_cyc%0d got req=%b we=%b be=%b wdata=%h addr=%h stall=%b exp 1 1 0100 abababab 00000100 %b",
                 i, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, stall_mw, (i < 3));
      end
      @(negedge clk);
    end
    opcode_mw = STORE; funct3_mw = 3'b001; alu_res_mw = 32'h102; store_data_mw = 32'h1234BEEF;
    dmem_gnt = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEFBEEF || stall_mw !== 1'b0) begin
      errors++;
      $display("FAIL sh got req=%b be=%b wdata=%h stall=%b exp 1 1100 beefbeef 0",
               dmem_req, dmem_be, dmem_wdata, stall_mw);
    end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if ({dmem_req, stall_mw} !== 2'b00) begin
      errors++; $display("FAIL store_done got req/stall=%b exp 00", {dmem_req, stall_mw});
    end
  endtask

  task automatic test_rst_in_wait();
    @(negedge clk);
    opcode_mw = LOAD; funct3_mw = 3'b010; wb_sel_mw = 2'b01; reg_wr_mw = 1'b1;
    alu_res_mw = 32'h200; dmem_gnt = 1'b1;
    #1;
    checks++;
    if ({dmem_req, stall_mw} !== 2'b11) begin
      errors++; $display("FAIL rst_wait_issue got req/stall=%b exp 11", {dmem_req, stall_mw});
    end
    @(negedge clk);
    rst = 1'b1; dmem_gnt = 1'b0;
    #1;
    checks++;
    if ({dmem_req, stall_mw, wb_en} !== 3'b000) begin
      errors++; $display("FAIL rst_wait_force got req/stall/wb_en=%b exp 000", {dmem_req, stall_mw, wb_en});
    end
    // Stale rvalid arrives in IDLE, then in REQ: both must be ignored.
    @(negedge clk);
    rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
    #1;
    checks++;
    if ({dmem_req, stall_mw, wb_en} !== 3'b110) begin
      errors++; $display("FAIL rst_stale_idle got req/stall/wb_en=%b exp 110", {dmem_req, stall_mw, wb_en});
    end
    @(negedge clk);
    dmem_gnt = 1'b1;
    #1;
    checks++;
    if ({dmem_req, stall_mw, wb_en} !== 3'b110) begin
      errors++; $display("FAIL rst_stale_req got req/stall/wb_en=%b exp 110", {dmem_req, stall_mw, wb_en});
    end
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rdata = 32'h22222222;
    #1;
    checks++;
    if ({dmem_req, stall_mw, wb_en} !== 3'b001 || wb_data !== 32'h22222222) begin
      errors++;
      $display("FAIL rst_reissue_done got req/stall/wb_en=%b data=%h exp 001 22222222",
               {dmem_req, stall_mw, wb_en}, wb_data);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_misalign();
    @(negedge clk);
    opcode_mw = STORE; funct3_mw = 3'b010; alu_res_mw = 32'h101; store_data_mw = 32'h12345678;
    dmem_gnt = 1'b1;
    #1;
    checks++;
`ifdef MISALIGN_TRAP_EN
    if ({dmem_req, misaligned, stall_mw, wb_en} !== 4'b0100) begin
      errors++;
      $display("FAIL misalign_sw got req/mis/stall/wb_en=%b exp 0100", {dmem_req, misaligned, stall_mw, wb_en});
    end
`else
    if (dmem_req !== 1'b1 || misaligned !== 1'b0 || stall_mw !== 1'b0 ||
        dmem_addr !== 32'h100 || dmem_be !== 4'b1111 || dmem_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL misalign_sw got req=%b mis=%b stall=%b addr=%h be=%b wdata=%h exp 1 0 0 00000100 1111 12345678",
               dmem_req, misaligned, stall_mw, dmem_addr, dmem_be, dmem_wdata);
    end
`endif
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_writeback();
    @(negedge clk);
    opcode_mw = OP; wb_sel_mw = 2'b00; reg_wr_mw = 1'b1; alu_res_mw = 32'h12345678;
    #1;
    checks++;
    if ({dmem_req, stall_mw, wb_en} !== 3'b001 || wb_data !== 32'h12345678) begin
      errors++;
      $display("FAIL wb_alu got req/stall/wb_en=%b data=%h exp 001 12345678", {dmem_req, stall_mw, wb_en}, wb_data);
    end
    @(negedge clk);
    opcode_mw = JAL; wb_sel_mw = 2'b10; pc_mw = 32'hFFFFFFFC;
    #1;
    checks++;
    if ({dmem_req, stall_mw, wb_en} !== 3'b001 || wb_data !== 32'h00000000) begin
      errors++;
      $display("FAIL wb_pc4_wrap got req/stall/wb_en=%b data=%h exp 001 00000000", {dmem_req, stall_mw, wb_en}, wb_data);
    end
    @(negedge clk);
    pc_mw = 32'h00001000;
    #1;
    checks++;
    if (wb_data !== 32'h00001004) begin
      errors++; $display("FAIL wb_pc4 got %h exp 00001004", wb_data);
    end
    @(negedge clk);
    opcode_mw = 7'b1110011; wb_sel_mw = 2'b11; csr_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (wb_en !== 1'b1 || wb_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL wb_csr got wb_en=%b data=%h exp 1 cafef00d", wb_en, wb_data);
    end
    @(negedge clk);
    set_idle();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_lanes();
    test_store();
    test_rst_in_wait();
    test_misalign();
    test_writeback();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
